// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default geometry for regfile_sb
package regfile_pkg;
    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int NRP_DEF = 2;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port; bypass compare present when REGFILE_SB_BYPASS_EN is defined
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   mem [2**AW],
    input  logic [2**AW-1:0] pend,
`ifdef REGFILE_SB_BYPASS_EN
    input  logic            byp_en,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
`endif
    output logic [DW-1:0]   rd_data,
    output logic            rd_pend
);
    logic hit;
`ifdef REGFILE_SB_BYPASS_EN
    assign hit = byp_en && waddr == rd_addr;
`else
    assign hit = 1'b0;
`endif
    // forwarded write data wins over the stored word and hides its pend bit
    always_comb begin
`ifdef REGFILE_SB_BYPASS_EN
        rd_data = hit ? wdata : mem[rd_addr];
`else
        rd_data = mem[rd_addr];
`endif
        rd_pend = hit ? 1'b0 : pend[rd_addr];
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with scoreboard pend bits and sequential bulk clear; optional write bypass via REGFILE_SB_BYPASS_EN
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NRP = NRP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*DW-1:0] rd_data,
    output logic [NRP-1:0]  rd_pend,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            clr_req,
    output logic            clr_busy
);
    logic [DW-1:0]     mem [2**AW];
    logic [2**AW-1:0]  pend;
    state_t            state;
    logic [AW-1:0]     idx;
    logic              wr_ok;
    logic              rsv_ok;
    assign wr_ok  = we && state == IDLE && waddr != '0;
    assign rsv_ok = rsv_en && state == IDLE && rsv_addr != '0;
`ifdef REGFILE_SB_BYPASS_EN
    logic byp_en;
    assign byp_en = rst && wr_ok;
`endif
    // array, scoreboard and clear sequencer; reservation is applied after the write so it wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2**AW; k++) mem[k] <= '0;
            pend     <= '0;
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
        end else if (state == IDLE) begin
            if (wr_ok) begin
                mem[waddr]  <= wdata;
                pend[waddr] <= 1'b0;
            end
            if (rsv_ok) pend[rsv_addr] <= 1'b1;
            if (clr_req) begin
                state    <= CLEAR;
                idx      <= AW'(1);
                clr_busy <= 1'b1;
            end
        end else begin
            mem[idx]  <= '0;
            pend[idx] <= 1'b0;
            idx       <= idx + 1'b1;
            if (idx == '1) begin
                state    <= IDLE;
                clr_busy <= 1'b0;
            end
        end
    end
    for (genvar i = 0; i < NRP; i++) begin : g_rp
        regfile_rdport #(.DW(DW), .AW(AW)) u_rp (
            .rd_addr (rd_addr[i*AW +: AW]),
            .mem     (mem),
            .pend    (pend),
`ifdef REGFILE_SB_BYPASS_EN
            .byp_en  (byp_en),
            .waddr   (waddr),
            .wdata   (wdata),
`endif
            .rd_data (rd_data[i*DW +: DW]),
            .rd_pend (rd_pend[i])
        );
    end
endmodule
